// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host receiver: FSM encodings, scancode
// prefixes, error codes and the frame parity helper.
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // A PS/2 frame is good when data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// Folds E0 (extended) and F0 (break) prefix bytes into single key events.
// Prefix flags are sticky until a non-prefix byte or a discarded frame.
module ps2_scancode_decoder
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid
);

    logic ext_pend;
    logic rel_pend;

    // Track prefixes and emit one key event per non-prefix byte.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ext_pend    <= 1'b0;
            rel_pend    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_err) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == PS2_PREFIX_EXT) begin
                    ext_pend <= 1'b1;
                end else if (byte_data == PS2_PREFIX_BRK) begin
                    rel_pend <= 1'b1;
                end else begin
                    key_valid   <= 1'b1;
                    key_code    <= byte_data;
                    key_ext     <= ext_pend;
                    key_release <= rel_pend;
                    ext_pend    <= 1'b0;
                    rel_pend    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the keyboard lines,
// deframes 11-bit frames into bytes and hands them to the scancode decoder.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for a falling edge with data low (start)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit, then parity; publish or drop
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [1:0] err_type,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_filt;
    logic [FW-1:0]          filt_cnt;
    logic                   fall_edge;
    ps2_state_t             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [TW-1:0]          to_cnt;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign busy   = (state != ST_IDLE);

    // Bring both asynchronous lines into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Debounce ps2_clk: flip the filtered level only after FILTER_LEN
    // consecutive differing samples; pulse fall_edge on a 1->0 flip.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            clk_filt  <= 1'b1;
            filt_cnt  <= FILT_LOAD;
            fall_edge <= 1'b0;
        end else begin
            fall_edge <= 1'b0;
            if (clk_s == clk_filt) begin
                filt_cnt <= FILT_LOAD;
            end else if (filt_cnt == '0) begin
                clk_filt  <= clk_s;
                filt_cnt  <= FILT_LOAD;
                fall_edge <= ~clk_s;
            end else begin
                filt_cnt <= filt_cnt - 1'b1;
            end
        end
    end

    // Frame FSM with inter-edge timeout; a real edge beats a same-cycle timeout.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            to_cnt     <= TO_LOAD;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_type   <= 2'b00;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall_edge || state == ST_IDLE) begin
                to_cnt <= TO_LOAD;
            end else if (to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end

            if (fall_edge) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg[bit_cnt] <= data_s;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= data_s;
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (!data_s) begin
                            frame_err <= 1'b1;
                            err_type  <= ERR_STOP;
                        end else if (!odd_parity_ok(shreg, par_bit)) begin
                            frame_err <= 1'b1;
                            err_type  <= ERR_PARITY;
                        end else begin
                            byte_data  <= shreg;
                            byte_valid <= 1'b1;
                        end
                    end
                endcase
            end else if (state != ST_IDLE && to_cnt == '0) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_type  <= ERR_TIMEOUT;
            end
        end
    end

    ps2_scancode_decoder u_decoder (
        .clk         (clk),
        .RST         (RST),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_err   (frame_err),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_valid   (key_valid)
    );

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
Synthesizable PS/2 host-side receiver. It is the device-to-host counterpart of the behavioural keyboard model used in the keyboard project benches. It samples the keyboard's PS2 clock/data lines in the system clock domain and deframes 11-bit PS/2 frames into bytes. It then folds the E0 (extended) and F0 (break) prefixes into single key events for the downstream keyboard logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (min 2).
FILTER_LEN, 8, consecutive equal synced samples needed before the filtered ps2_clk level changes.
TIMEOUT_CYCLES, 10000, clk cycles allowed between filtered falling edges inside a frame (200 us at 50 MHz).

Ports:
clk  in  1  system clock
RST  in  1  reset, asynchronous, active-low
ps2_clk  in  1  PS/2 clock line from keyboard (asynchronous)
ps2_data  in  1  PS/2 data line from keyboard (asynchronous)
byte_data  out  8  last received byte, LSB-first deframed
byte_valid  out  1  one-cycle strobe, byte_data valid
frame_err  out  1  one-cycle strobe, frame discarded
err_type  out  2  01 parity, 10 stop bit, 11 timeout; held until next frame_err
key_code  out  8  scancode of completed key event
key_ext  out  1  event was E0-prefixed
key_release  out  1  event was F0-prefixed (break)
key_valid  out  1  one-cycle strobe, key_* valid
busy  out  1  frame reception in progress (FSM not IDLE)

Behaviour:
- RST low: all outputs 0, FSM IDLE, filtered clk = 1, sync regs = 1, prefix flags cleared. Effective immediately, including mid-frame; a partial frame is dropped silently with no frame_err.
- Input path: both lines pass through SYNC_STAGES flops. The clk filter counter flips the filtered level after FILTER_LEN equal samples that differ from the current level. A fall_edge strobe lasts 1 cycle. Data is sampled from the synced ps2_data on fall_edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_edge with data=0 -> DATA, bit_cnt=0. Data=1 (no start bit) is ignored, with no error.
  - DATA: each fall_edge shifts the data bit into shreg[bit_cnt] (LSB first). After the 8th bit -> PARITY.
  - PARITY: latch the bit -> STOP.
  - STOP: on fall_edge, check the stop bit first, then odd parity over 8 data bits + parity bit.
    - Stop bit must be 1, else err 10.
    - Parity must be odd, else err 01.
    - Success: byte_data<=shreg and byte_valid=1 in the cycle after that fall_edge.
    - Always -> IDLE.
- Timeout: the counter clears on every fall_edge and in IDLE. If it reaches TIMEOUT_CYCLES while not IDLE -> IDLE, frame_err with err_type 11. If fall_edge and the terminal count occur in the same cycle, the edge wins.
- byte_valid and frame_err are never asserted together.
- Scancode decoder (consumes byte_valid, 1-cycle latency):
  - 0xE0: ext_pend<=1, no event.
  - 0xF0: rel_pend<=1, no event.
  - Any other byte: key_valid=1, key_code=byte, key_ext=ext_pend, key_release=rel_pend, both flags cleared.
  - frame_err clears both flags.
  - Repeated prefixes stay set (idempotent).
  - 0xE1 and other bytes pass through as ordinary codes.
- key_code/key_ext/key_release hold their last value between strobes. byte_data likewise.
- Total latency from the stop-bit fall_edge to key_valid: 2 clk cycles.

Decomposition:
- Package ps2_pkg: FSM state enum, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, ERR_PARITY=2'b01, ERR_STOP=2'b10, ERR_TIMEOUT=2'b11.
- Sub-module ps2_scancode_decoder: byte_valid/byte_data/frame_err in, key_* out, owns the prefix flags.
- Sync, filter, FSM and timeout stay in ps2_host_rx.

Test Plan:
- Drive the keyboard model send_scancode(8'h0F) -> byte_valid once with byte_data=0x0F. Two cycles after the stop edge, key_valid with key_code=0x0F, key_ext=0, key_release=0. frame_err never asserted.
- Type 'a' (1C, F0 1C) -> key_valid(0x1C, ext0, rel0), then key_valid(0x1C, ext0, rel1). Exactly 2 key events from 3 bytes.
- Right alt press/release (E0 11, E0 F0 11) -> key_valid(0x11, ext1, rel0), then key_valid(0x11, ext1, rel1).
- Frame 0x1C with the parity bit inverted -> frame_err with err_type=01 and no byte_valid. The following valid 0x1C frame yields byte_valid 0x1C. A stop bit forced 0 -> err_type=10.
- Stop clocking after 5 data bits, idle 10000+ cycles -> frame_err, err_type=11, busy falls. The next full 0x29 frame is received correctly. A 3-cycle low glitch on ps2_clk in IDLE produces no fall_edge and no state change.
- Assert RST mid-frame (after 4 bits) -> all outputs 0 immediately, no frame_err. After release, E0 followed by a good 0x75 yields key_ext=1; a stale prefix must not leak across reset.
